// File: rtl/matmul_seq_pkg.sv
// Shared types and pipeline constants for the sequential matrix-multiply sequencer.
package matmul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Stage (counted from the read issue) where the MAC sees data and where C is written back.
  localparam int READ_LAT = 1;
  localparam int WB_LAT   = 2;

endpackage

// File: rtl/matmul_seq_idx_addr_gen.sv
// i/j/k loop counters (k fastest) with incremental row-major A, B and C addresses.
module idx_addr_gen #(
  parameter int ADDR_MSB         = 11,
  parameter int MAT_IDX_SIZE_MSB = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_step,
  input  logic [MAT_IDX_SIZE_MSB:0] i_m_last,
  input  logic [MAT_IDX_SIZE_MSB:0] i_k_last,
  input  logic [MAT_IDX_SIZE_MSB:0] i_n_last,
  output logic [ADDR_MSB:0]       o_a_addr,
  output logic [ADDR_MSB:0]       o_b_addr,
  output logic [ADDR_MSB:0]       o_c_addr,
  output logic                    o_k_first,
  output logic                    o_k_end,
  output logic                    o_final
);

  localparam int AW = ADDR_MSB + 1;
  localparam logic [MAT_IDX_SIZE_MSB:0] IDX_ONE  = 1;
  localparam logic [ADDR_MSB:0]         ADDR_ONE = 1;

  logic [MAT_IDX_SIZE_MSB:0] r_i, r_j, r_k;
  logic [ADDR_MSB:0]         r_a_addr, r_b_addr, r_c_addr, r_a_row;
  logic [ADDR_MSB:0]         w_k_stride, w_n_stride;
  logic                      w_k_end, w_j_end, w_i_end;

  assign w_k_stride = AW'(i_k_last) + ADDR_ONE;
  assign w_n_stride = AW'(i_n_last) + ADDR_ONE;
  assign w_k_end    = (r_k == i_k_last);
  assign w_j_end    = (r_j == i_n_last);
  assign w_i_end    = (r_i == i_m_last);

  // NOTE: all state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_c_addr <= '0;
      r_a_row  <= '0;
    end else if (i_step && !o_final) begin
      if (!w_k_end) begin
        r_k      <= r_k + IDX_ONE;
        r_a_addr <= r_a_addr + ADDR_ONE;
        r_b_addr <= r_b_addr + w_n_stride;
      end else begin
        r_k      <= '0;
        r_c_addr <= r_c_addr + ADDR_ONE;
        if (!w_j_end) begin
          r_j      <= r_j + IDX_ONE;
          r_a_addr <= r_a_row;
          r_b_addr <= AW'(r_j) + ADDR_ONE;
        end else begin
          // New row of A: row base advances by one row length.
          r_j      <= '0;
          r_i      <= r_i + IDX_ONE;
          r_a_row  <= r_a_row + w_k_stride;
          r_a_addr <= r_a_row + w_k_stride;
          r_b_addr <= '0;
        end
      end
    end
  end

  assign o_a_addr  = r_a_addr;
  assign o_b_addr  = r_b_addr;
  assign o_c_addr  = r_c_addr;
  assign o_k_first = (r_k == '0);
  assign o_k_end   = w_k_end;
  assign o_final   = w_k_end && w_j_end && w_i_end;

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for C = A x B: issues operand reads, drives MAC accumulate controls and C write-back.
module matmul_seq
  import matmul_seq_pkg::*;
#(
  parameter int ADDR_MSB         = 11,
  parameter int MAT_IDX_SIZE_MSB = 3
) (
  input  logic                      CLK,
  input  logic                      RST_L,
  input  logic                      start,
  input  logic                      hold,
  input  logic [MAT_IDX_SIZE_MSB:0] m_last,
  input  logic [MAT_IDX_SIZE_MSB:0] k_last,
  input  logic [MAT_IDX_SIZE_MSB:0] n_last,
  output logic                      a_re,
  output logic                      b_re,
  output logic [ADDR_MSB:0]         a_addr,
  output logic [ADDR_MSB:0]         b_addr,
  output logic [ADDR_MSB:0]         c_addr,
  output logic                      acc_en,
  output logic                      acc_clr,
  output logic                      c_we,
  output logic                      busy,
  output logic                      done
);

  state_t                    r_state, w_state_nxt;
  logic [MAT_IDX_SIZE_MSB:0] r_m_last, r_k_last, r_n_last;
  logic                      w_start_ok, w_issue;
  logic [ADDR_MSB:0]         w_c_addr;
  logic                      w_k_first, w_k_end, w_final;

  logic [WB_LAT-1:0]         r_vld, r_kfirst, r_kend;
  logic [ADDR_MSB:0]         r_caddr_pipe [WB_LAT];

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_issue    = (r_state == ST_ISSUE) && !hold;

  idx_addr_gen #(
    .ADDR_MSB         (ADDR_MSB),
    .MAT_IDX_SIZE_MSB (MAT_IDX_SIZE_MSB)
  ) u_idx_addr_gen (
    .clk       (CLK),
    .rst_n     (RST_L),
    .i_clear   (w_start_ok),
    .i_step    (w_issue),
    .i_m_last  (r_m_last),
    .i_k_last  (r_k_last),
    .i_n_last  (r_n_last),
    .o_a_addr  (a_addr),
    .o_b_addr  (b_addr),
    .o_c_addr  (w_c_addr),
    .o_k_first (w_k_first),
    .o_k_end   (w_k_end),
    .o_final   (w_final)
  );

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      r_state  <= ST_IDLE;
      r_m_last <= '0;
      r_k_last <= '0;
      r_n_last <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_m_last <= m_last;
        r_k_last <= k_last;
        r_n_last <= n_last;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_issue && w_final) w_state_nxt = ST_DRAIN;
      // Leave once only the write-back stage can still hold a valid entry.
      ST_DRAIN: if (!(|r_vld[WB_LAT-2:0])) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: this small address array is reset because c_addr must read 0 after reset;
  // a true storage RAM would be left unreset.
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      r_vld    <= '0;
      r_kfirst <= '0;
      r_kend   <= '0;
      for (int s = 0; s < WB_LAT; s++) r_caddr_pipe[s] <= '0;
    end else begin
      r_vld[0] <= w_issue;
      if (w_issue) begin
        r_kfirst[0]     <= w_k_first;
        r_kend[0]       <= w_k_end;
        r_caddr_pipe[0] <= w_c_addr;
      end
      for (int s = 1; s < WB_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_kfirst[s]     <= r_kfirst[s-1];
          r_kend[s]       <= r_kend[s-1];
          r_caddr_pipe[s] <= r_caddr_pipe[s-1];
        end
      end
    end
  end

  assign a_re    = w_issue;
  assign b_re    = w_issue;
  assign acc_en  = r_vld[READ_LAT-1];
  assign acc_clr = r_vld[READ_LAT-1] && r_kfirst[READ_LAT-1];
  assign c_we    = r_vld[WB_LAT-1] && r_kend[WB_LAT-1];
  assign c_addr  = r_caddr_pipe[WB_LAT-1];
  assign busy    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: per-cycle output log checked against a loop-order schedule model.
module tb_matmul_seq;

  logic        CLK, RST_L, start, hold;
  logic [3:0]  m_last, k_last, n_last;
  logic        a_re, b_re, acc_en, acc_clr, c_we, busy, done;
  logic [11:0] a_addr, b_addr, c_addr;

  int total = 0;
  int bad   = 0;

  localparam int LG = 48;
  logic [31:0] lg_are [LG], lg_bre [LG], lg_aaddr [LG], lg_baddr [LG], lg_caddr [LG];
  logic [31:0] lg_acc [LG], lg_clr [LG], lg_cwe [LG], lg_busy [LG], lg_done [LG];

  matmul_seq dut (
    .CLK     (CLK),
    .RST_L   (RST_L),
    .start   (start),
    .hold    (hold),
    .m_last  (m_last),
    .k_last  (k_last),
    .n_last  (n_last),
    .a_re    (a_re),
    .b_re    (b_re),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .c_addr  (c_addr),
    .acc_en  (acc_en),
    .acc_clr (acc_clr),
    .c_we    (c_we),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start accepted at edge 0; cycle n is the period after edge n-1, sampled at its falling edge.
  task automatic run_op(input int ml, kl, nl, hlo, hhi, s1, s2, rc, ncyc);
    @(posedge CLK); #1;
    m_last = 4'(ml); k_last = 4'(kl); n_last = 4'(nl);
    start = 1'b1; hold = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge CLK); #1;
      start = (n == s1) || (n == s2);
      hold  = (n >= hlo) && (n <= hhi);
      RST_L = (n != rc);
      if (n == 2) begin
        m_last = 4'hf; k_last = 4'hf; n_last = 4'hf;
      end
      @(negedge CLK);
      lg_are[n] = 32'(a_re);     lg_bre[n] = 32'(b_re);
      lg_aaddr[n] = 32'(a_addr); lg_baddr[n] = 32'(b_addr); lg_caddr[n] = 32'(c_addr);
      lg_acc[n] = 32'(acc_en);   lg_clr[n] = 32'(acc_clr);  lg_cwe[n] = 32'(c_we);
      lg_busy[n] = 32'(busy);    lg_done[n] = 32'(done);
    end
    start = 1'b0; hold = 1'b0; RST_L = 1'b1;
  endtask

  // Expected schedule built from the loop order and address formulas, then compared cycle by cycle.
  task automatic check_run(input string tag, input int ml, kl, nl, hlo, hhi, ncyc);
    int e_re [LG], e_a [LG], e_b [LG], e_acc [LG], e_clr [LG], e_we [LG], e_c [LG];
    int c, last_we;
    for (int n = 0; n < LG; n++) begin
      e_re[n] = 0; e_a[n] = 0; e_b[n] = 0; e_acc[n] = 0; e_clr[n] = 0; e_we[n] = 0; e_c[n] = 0;
    end
    c = 1; last_we = 0;
    for (int i = 0; i <= ml; i++)
      for (int j = 0; j <= nl; j++)
        for (int k = 0; k <= kl; k++) begin
          while (c >= hlo && c <= hhi) c++;
          e_re[c] = 1;
          e_a[c] = (i * (kl + 1) + k) % 4096;
          e_b[c] = (k * (nl + 1) + j) % 4096;
          e_acc[c+1] = 1;
          e_clr[c+1] = (k == 0) ? 1 : 0;
          if (k == kl) begin
            e_we[c+2] = 1;
            e_c[c+2] = (i * (nl + 1) + j) % 4096;
            last_we = c + 2;
          end
          c++;
        end
    for (int n = 1; n <= ncyc; n++) begin
      check($sformatf("%s_are_c%0d", tag, n), lg_are[n], 32'(e_re[n]));
      check($sformatf("%s_bre_c%0d", tag, n), lg_bre[n], 32'(e_re[n]));
      if (e_re[n] != 0) begin
        check($sformatf("%s_aaddr_c%0d", tag, n), lg_aaddr[n], 32'(e_a[n]));
        check($sformatf("%s_baddr_c%0d", tag, n), lg_baddr[n], 32'(e_b[n]));
      end
      check($sformatf("%s_accen_c%0d", tag, n), lg_acc[n], 32'(e_acc[n]));
      check($sformatf("%s_accclr_c%0d", tag, n), lg_clr[n], 32'(e_clr[n]));
      check($sformatf("%s_cwe_c%0d", tag, n), lg_cwe[n], 32'(e_we[n]));
      if (e_we[n] != 0) check($sformatf("%s_caddr_c%0d", tag, n), lg_caddr[n], 32'(e_c[n]));
      check($sformatf("%s_busy_c%0d", tag, n), lg_busy[n], (n <= last_we) ? 32'd1 : 32'd0);
      check($sformatf("%s_done_c%0d", tag, n), lg_done[n], (n == last_we + 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int we_count;
    RST_L = 1'b0; start = 1'b0; hold = 1'b0;
    m_last = '0; k_last = '0; n_last = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_are", 32'(a_re), 0);       check("rst_bre", 32'(b_re), 0);
    check("rst_accen", 32'(acc_en), 0);   check("rst_accclr", 32'(acc_clr), 0);
    check("rst_cwe", 32'(c_we), 0);       check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);      check("rst_aaddr", 32'(a_addr), 0);
    check("rst_baddr", 32'(b_addr), 0);   check("rst_caddr", 32'(c_addr), 0);
    RST_L = 1'b1;

    // 1x1x1 product
    run_op(0, 0, 0, 0, -1, 0, 0, 0, 8);
    check("r032_are_c1", lg_are[1], 1);
    check("r032_accclr_c2", lg_clr[2], 1);
    check("r032_cwe_c3", lg_cwe[3], 1);
    check("r032_caddr_c3", lg_caddr[3], 0);
    check("r032_done_c4", lg_done[4], 1);
    check_run("r032", 0, 0, 0, 0, -1, 8);

    // 2x3 * 3x2, no hold
    run_op(1, 2, 1, 0, -1, 0, 0, 0, 20);
    check("r033_cwe_c5", lg_cwe[5], 1);    check("r033_caddr_c5", lg_caddr[5], 0);
    check("r033_cwe_c8", lg_cwe[8], 1);    check("r033_caddr_c8", lg_caddr[8], 1);
    check("r033_cwe_c11", lg_cwe[11], 1);  check("r033_caddr_c11", lg_caddr[11], 2);
    check("r033_cwe_c14", lg_cwe[14], 1);  check("r033_caddr_c14", lg_caddr[14], 3);
    check("r033_done_c15", lg_done[15], 1);
    check("r034_read5_aaddr", lg_aaddr[5], 1);
    check("r034_read5_baddr", lg_baddr[5], 3);
    check_run("r033", 1, 2, 1, 0, -1, 20);

    // hold during cycles 3..5
    run_op(1, 2, 1, 3, 5, 0, 0, 0, 22);
    check("r035_are_c3", lg_are[3], 0);
    check("r035_accen_c3", lg_acc[3], 1);
    check("r035_done_c18", lg_done[18], 1);
    check_run("r035", 1, 2, 1, 3, 5, 22);

    // start pulses while busy and in the DONE cycle are ignored
    run_op(1, 2, 1, 0, -1, 4, 15, 0, 22);
    we_count = 0;
    for (int n = 1; n <= 22; n++) we_count += int'(lg_cwe[n]);
    check("r036_cwe_count", 32'(we_count), 4);
    check_run("r036", 1, 2, 1, 0, -1, 22);

    // reset sampled at the end of cycle 6 abandons the operation
    run_op(1, 2, 1, 0, -1, 0, 0, 6, 20);
    for (int n = 1; n <= 6; n++) check($sformatf("r037_are_c%0d", n), lg_are[n], 1);
    check("r037_cwe_c5", lg_cwe[5], 1);
    check("r037_caddr_c5", lg_caddr[5], 0);
    for (int n = 7; n <= 20; n++) begin
      check($sformatf("r037_are_c%0d", n), lg_are[n], 0);
      check($sformatf("r037_accen_c%0d", n), lg_acc[n], 0);
      check($sformatf("r037_cwe_c%0d", n), lg_cwe[n], 0);
      check($sformatf("r037_busy_c%0d", n), lg_busy[n], 0);
      check($sformatf("r037_done_c%0d", n), lg_done[n], 0);
      check($sformatf("r037_addr_c%0d", n), lg_aaddr[n] | lg_baddr[n] | lg_caddr[n], 0);
    end
    run_op(1, 2, 1, 0, -1, 0, 0, 0, 20);
    check_run("r037_fresh", 1, 2, 1, 0, -1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
